vfill: RTL and testbench

- Rectangle fill engine that sits directly upstream of the VMMU write-request port, in the MemClk domain.
- Takes one fill command (start address, width, height, line stride, colour byte) and emits one write request per pixel, row-major.
- Uses the same WriteDataIn/WriteAddrIn/PushWriteReq strobe protocol the command decoder uses.
- Honours WriteReqQueueFull back-pressure so that no write is dropped. Used for screen clears and solid boxes without SPI traffic per pixel.

---
 rtl/vfill_pkg.sv | 17 +
 rtl/vfill_if.sv | 40 ++++
 rtl/vfill_addrgen.sv | 63 ++++++
 rtl/vfill.sv | 110 +++++++++++
 tb/tb_vfill.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vfill_pkg.sv
// Shared widths and FSM encoding for the
// rectangle fill engine.
package vga_pkg;

  localparam int AWIDTH = 19;
  localparam int DWIDTH = 8;
  localparam int XWIDTH = 10;
  localparam int YWIDTH = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/vfill_if.sv
// Command and VMMU write-request bundle
// for the fill engine.
interface vfill_if #(
  parameter int AW = vga_pkg::AWIDTH,
  parameter int DW = vga_pkg::DWIDTH,
  parameter int XW = vga_pkg::XWIDTH,
  parameter int YW = vga_pkg::YWIDTH
) ();

  logic          Start;
  logic          Abort;
  logic [AW-1:0] StartAddr;
  logic [XW-1:0] Width;
  logic [YW-1:0] Height;
  logic [AW-1:0] Stride;
  logic [DW-1:0] Color;
  logic          WriteReqQueueFull;
  logic [DW-1:0] WriteDataOut;
  logic [AW-1:0] WriteAddrOut;
  logic          PushWriteReq;
  logic          Busy;
  logic          Done;

  modport master (
    input  Start, Abort, StartAddr,
    input  Width, Height, Stride, Color,
    input  WriteReqQueueFull,
    output WriteDataOut, WriteAddrOut,
    output PushWriteReq, Busy, Done
  );

  modport slave (
    output Start, Abort, StartAddr,
    output Width, Height, Stride, Color,
    output WriteReqQueueFull,
    input  WriteDataOut, WriteAddrOut,
    input  PushWriteReq, Busy, Done
  );

endinterface

// File: rtl/vfill_addrgen.sv
// Row-major pixel walker: column/row counters,
// row base and current address.
module vfill_addrgen
  import vga_pkg::*;
#(
  parameter int AW = vga_pkg::AWIDTH,
  parameter int XW = vga_pkg::XWIDTH,
  parameter int YW = vga_pkg::YWIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] stride,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] addr_nxt,
  output logic          last
);

  logic [XW-1:0] col, w_q;
  logic [YW-1:0] row, h_q;
  logic [AW-1:0] row_addr, stride_q;
  logic [AW-1:0] row_nxt;
  logic          eol;

  assign eol      = col == w_q - 1'b1;
  assign last     = eol && (row == h_q - 1'b1);
  assign row_nxt  = row_addr + stride_q;
  assign addr_nxt = eol ? row_nxt : addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      stride_q <= '0;
      row_addr <= '0;
      addr     <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      w_q      <= width;
      h_q      <= height;
      stride_q <= stride;
      row_addr <= start_addr;
      addr     <= start_addr;
    end else if (adv) begin
      if (eol) begin
        col      <= '0;
        row      <= row + 1'b1;
        row_addr <= row_nxt;
      end else begin
        col <= col + 1'b1;
      end
      addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/vfill.sv
// Rectangle fill engine feeding the VMMU write
// port; one push per pixel, low cycle between.
module vfill
  import vga_pkg::*;
#(
  parameter int AWIDTH = vga_pkg::AWIDTH,
  parameter int DWIDTH = vga_pkg::DWIDTH,
  parameter int XWIDTH = vga_pkg::XWIDTH,
  parameter int YWIDTH = vga_pkg::YWIDTH
) (
  input  logic   MemClk,
  input  logic   Reset,
  vfill_if.master bus
);

  state_t state, state_nxt;

  logic              abort_q, abort_nxt, abort_any;
  logic              load, adv, push, zero, last;
  logic [AWIDTH-1:0] addr, addr_nxt;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] wdata;

  assign zero      = (bus.Width == '0) || (bus.Height == '0);
  assign abort_any = bus.Abort | abort_q;

  vfill_addrgen #(
    .AW (AWIDTH),
    .XW (XWIDTH),
    .YW (YWIDTH)
  ) u_addrgen (
    .clk        (MemClk),
    .rst        (Reset),
    .load       (load),
    .adv        (adv),
    .start_addr (bus.StartAddr),
    .stride     (bus.Stride),
    .width      (bus.Width),
    .height     (bus.Height),
    .addr       (addr),
    .addr_nxt   (addr_nxt),
    .last       (last)
  );

  always_comb begin
    state_nxt = state;
    abort_nxt = abort_q;
    load      = 1'b0;
    adv       = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (bus.Start) begin
          load      = 1'b1;
          state_nxt = zero ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        abort_nxt = abort_any;
        if (bus.WriteReqQueueFull) begin
          if (abort_any) state_nxt = FINISH;
        end else begin
          push      = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        abort_nxt = abort_any;
        adv       = 1'b1;
        state_nxt = (last || abort_any) ? FINISH : ISSUE;
      end
      FINISH: begin
        abort_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MemClk) begin
    if (Reset) begin
      state   <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort_nxt;
    end
  end

  // Address/data are loaded ahead of ISSUE so they are valid with the strobe
  always_ff @(posedge MemClk) begin
    if (Reset) begin
      waddr <= '0;
      wdata <= '0;
    end else if (state == IDLE && bus.Start && !zero) begin
      waddr <= bus.StartAddr;
      wdata <= bus.Color;
    end else if (state == GAP && state_nxt == ISSUE) begin
      waddr <= addr_nxt;
    end
  end

  assign bus.WriteAddrOut = waddr;
  assign bus.WriteDataOut = wdata;
  assign bus.PushWriteReq = push;
  assign bus.Busy         = state != IDLE;
  assign bus.Done         = state == FINISH;

endmodule

// File: tb/tb_vfill.sv
// Directed vector bench for the vfill rectangle
// fill engine.
module tb_vfill;

  localparam int AW = 19;

  typedef struct {
    logic [18:0] sa;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [18:0] st;
    logic [7:0]  c;
    int          np;
    int          busy;
    logic [18:0] last;
  } vec_t;

  logic MemClk = 1'b0;
  logic Reset  = 1'b1;

  vfill_if bus ();

  vfill dut (
    .MemClk (MemClk),
    .Reset  (Reset),
    .bus    (bus)
  );

  always #5 MemClk = ~MemClk;

  int cyc = 0;
  always @(posedge MemClk) cyc <= cyc + 1;

  logic [AW-1:0] pa_q[$];
  logic [7:0]    pd_q[$];
  int            pc_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int adj_err  = 0;
  int full_err = 0;
  logic prev_push = 1'b0;

  always @(negedge MemClk) begin
    if (bus.PushWriteReq === 1'b1) begin
      pa_q.push_back(bus.WriteAddrOut);
      pd_q.push_back(bus.WriteDataOut);
      pc_q.push_back(cyc);
      if (prev_push) adj_err++;
      if (bus.WriteReqQueueFull) full_err++;
    end
    prev_push = bus.PushWriteReq;
    if (bus.Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.Busy === 1'b1) busy_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic start_cmd(input vec_t t, output int c0);
    @(posedge MemClk); #1;
    bus.Start     = 1'b1;
    bus.StartAddr = t.sa;
    bus.Width     = t.w;
    bus.Height    = t.h;
    bus.Stride    = t.st;
    bus.Color     = t.c;
    c0 = cyc;
    @(posedge MemClk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic wait_pushes(input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (pa_q.size() >= n) break;
      @(negedge MemClk); #1;
    end
    chk("push_wait", pa_q.size() >= n, 1);
  endtask

  task automatic wait_done(input int base, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (done_cnt > base) break;
      @(negedge MemClk); #1;
    end
    chk("done_wait", done_cnt > base, 1);
    repeat (2) @(negedge MemClk);
    #1;
  endtask

  function automatic logic [18:0] model_addr(input vec_t t, input int k);
    longint a;
    a = longint'(t.sa) + longint'(k / int'(t.w)) * longint'(t.st)
        + longint'(k % int'(t.w));
    return a[18:0];
  endfunction

  task automatic run_vec(input vec_t t);
    int pb, db, bb, ab, c0;
    pb = pa_q.size();
    db = done_cnt;
    bb = busy_cnt;
    ab = adj_err;
    start_cmd(t, c0);
    wait_done(db, 4 * t.np + 20);
    chk("pushes", pa_q.size() - pb, t.np);
    chk("busy_cycles", busy_cnt - bb, t.busy);
    chk("done_pulses", done_cnt - db, 1);
    chk("done_latency", done_cyc - c0, t.busy);
    chk("strobe_gap", adj_err - ab, 0);
    for (int k = 0; k < t.np && pb + k < pa_q.size(); k++) begin
      chk("addr", pa_q[pb+k], model_addr(t, k));
      chk("data", pd_q[pb+k], t.c);
      if (k == 0) chk("first_latency", pc_q[pb] - c0, 1);
      else chk("push_spacing", pc_q[pb+k] - pc_q[pb+k-1], 2);
    end
    if (t.np > 0 && pa_q.size() >= pb + t.np) begin
      chk("last_addr", pa_q[pb+t.np-1], t.last);
      chk("hold_addr", bus.WriteAddrOut, t.last);
      chk("hold_data", bus.WriteDataOut, t.c);
    end
  endtask

  vec_t v[7];

  initial begin
    vec_t t;
    int pb, db, bb, c0, fb;

    v[0] = '{19'd100, 10'd3, 10'd2, 19'd640, 8'h2A, 6, 13, 19'd742};
    v[1] = '{19'h123, 10'd0, 10'd5, 19'd640, 8'h55, 0, 1, 19'd0};
    v[2] = '{19'h7FFFE, 10'd4, 10'd1, 19'd0, 8'hFF, 4, 9, 19'h00001};
    v[3] = '{19'd7, 10'd3, 10'd0, 19'd9, 8'h11, 0, 1, 19'd0};
    v[4] = '{19'h40000, 10'd1, 10'd1, 19'd5, 8'h01, 1, 3, 19'h40000};
    v[5] = '{19'h7FF00, 10'd2, 10'd3, 19'h100, 8'hA5, 6, 13, 19'h00101};
    v[6] = '{19'd10, 10'd1, 10'd3, 19'd2, 8'h5A, 3, 7, 19'd14};

    bus.Start = 0;
    bus.Abort = 0;
    bus.StartAddr = '0;
    bus.Width = '0;
    bus.Height = '0;
    bus.Stride = '0;
    bus.Color = '0;
    bus.WriteReqQueueFull = 0;

    repeat (3) @(posedge MemClk);
    #1 Reset = 1'b0;
    @(negedge MemClk);
    chk("rst_push", bus.PushWriteReq, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_addr", bus.WriteAddrOut, 0);
    chk("rst_data", bus.WriteDataOut, 0);

    for (int i = 0; i < 7; i++) run_vec(v[i]);

    // back-pressure on the second pixel of a 4x1 fill
    t = '{19'h200, 10'd4, 10'd1, 19'd0, 8'h3C, 4, 12, 19'h203};
    pb = pa_q.size(); db = done_cnt; bb = busy_cnt; fb = full_err;
    start_cmd(t, c0);
    wait_pushes(pb + 1, 20);
    @(posedge MemClk); #1 bus.WriteReqQueueFull = 1'b1;
    repeat (4) @(posedge MemClk);
    #1 bus.WriteReqQueueFull = 1'b0;
    wait_done(db, 40);
    chk("bp_pushes", pa_q.size() - pb, 4);
    chk("bp_push_while_full", full_err - fb, 0);
    chk("bp_busy", busy_cnt - bb, 12);
    chk("bp_done", done_cnt - db, 1);
    for (int k = 0; k < 4 && pb + k < pa_q.size(); k++)
      chk("bp_addr", pa_q[pb+k], 19'h200 + k);

    // abort after the third push of a 10x10 fill
    t = '{19'h1000, 10'd10, 10'd10, 19'd640, 8'hC3, 3, 7, 19'h1002};
    pb = pa_q.size(); db = done_cnt; bb = busy_cnt;
    start_cmd(t, c0);
    wait_pushes(pb + 3, 40);
    @(posedge MemClk); #1 bus.Abort = 1'b1;
    @(posedge MemClk); #1 bus.Abort = 1'b0;
    wait_done(db, 40);
    chk("abort_pushes", pa_q.size() - pb, 3);
    chk("abort_done", done_cnt - db, 1);
    chk("abort_busy", busy_cnt - bb, 7);
    run_vec(v[0]);

    // abort while the queue is full in ISSUE
    t = '{19'h300, 10'd5, 10'd1, 19'd0, 8'h0F, 1, 4, 19'h300};
    pb = pa_q.size(); db = done_cnt; bb = busy_cnt;
    start_cmd(t, c0);
    wait_pushes(pb + 1, 20);
    @(posedge MemClk); #1 bus.WriteReqQueueFull = 1'b1;
    @(posedge MemClk); #1 bus.Abort = 1'b1;
    @(posedge MemClk); #1;
    bus.Abort = 1'b0;
    bus.WriteReqQueueFull = 1'b0;
    wait_done(db, 40);
    chk("abort_full_pushes", pa_q.size() - pb, 1);
    chk("abort_full_done", done_cnt - db, 1);
    chk("abort_full_busy", busy_cnt - bb, 4);

    // reset in GAP of a 100x100 fill
    t = '{19'd0, 10'd100, 10'd100, 19'd640, 8'h77, 0, 0, 19'd0};
    pb = pa_q.size();
    start_cmd(t, c0);
    wait_pushes(pb + 5, 40);
    @(posedge MemClk); #1 Reset = 1'b1;
    @(posedge MemClk); #1 Reset = 1'b0;
    @(negedge MemClk);
    chk("mid_rst_push", bus.PushWriteReq, 0);
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_addr", bus.WriteAddrOut, 0);
    chk("mid_rst_data", bus.WriteDataOut, 0);
    pb = pa_q.size(); db = done_cnt; bb = busy_cnt;
    repeat (20) @(negedge MemClk);
    chk("post_rst_pushes", pa_q.size() - pb, 0);
    chk("post_rst_done", done_cnt - db, 0);
    chk("post_rst_busy", busy_cnt - bb, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
